// File: rtl/iic_reg_arbiter.sv
// iic_reg_arbiter
//   Round-robin arbiter between two single-word command requesters (0: I2C
//   engine, 1: housekeeping) and an AXI4-Lite master that serialises their
//   commands onto the register slave, one transaction outstanding at a time.
// Ports
//   ACLK, ARESET             clock, synchronous active-high reset
//   REQn_VALID/WE/ADDR/WDATA command in; REQn_READY accept (IDLE only)
//   REQn_DONE                one-cycle completion pulse to the owner
//   RSP_RDATA, RSP_RESP      result of the last completed command
//   M_AXI_*                  AXI4-Lite master (AW, W, B, AR, R channels)
module iic_reg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            REQ0_VALID,
  input  logic                            REQ0_WE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ0_WDATA,
  output logic                            REQ0_READY,
  output logic                            REQ0_DONE,
  input  logic                            REQ1_VALID,
  input  logic                            REQ1_WE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ1_WDATA,
  output logic                            REQ1_READY,
  output logic                            REQ1_DONE,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_e;

  state_e          state_q;
  logic            last_grant_q, grant_q;
  logic [AW-1:2]   addr_q;       // word index only; byte offset is dropped
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [1:0]      resp_q;
  logic            awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic            done0_q, done1_q;

  logic            grant_d, accept, aw_left, w_left;
  logic            sel_we;
  logic [AW-1:2]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^{REQ0_ADDR[1:0], REQ1_ADDR[1:0]};

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_d = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) grant_d = ~last_grant_q;
  end

  assign accept     = (state_q == IDLE) && (REQ0_VALID || REQ1_VALID);
  assign REQ0_READY = accept && !grant_d;
  assign REQ1_READY = accept &&  grant_d;

  assign sel_we    = grant_d ? REQ1_WE           : REQ0_WE;
  assign sel_addr  = grant_d ? REQ1_ADDR[AW-1:2] : REQ0_ADDR[AW-1:2];
  assign sel_wdata = grant_d ? REQ1_WDATA        : REQ0_WDATA;

  // A channel is still outstanding if its VALID is up and not taken this cycle.
  assign aw_left = awvalid_q && !M_AXI_AWREADY;
  assign w_left  = wvalid_q  && !M_AXI_WREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          grant_q      <= grant_d;
          last_grant_q <= grant_d;
          addr_q       <= sel_addr;
          wdata_q      <= sel_wdata;
          if (sel_we) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR_ADDR;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= RD_ADDR;
          end
        end
        WR_ADDR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          bready_q <= 1'b0;
          rdata_q  <= '0;
          resp_q   <= M_AXI_BRESP;
          done0_q  <= !grant_q;
          done1_q  <=  grant_q;
          state_q  <= DONE;
        end
        RD_ADDR: if (M_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          rready_q <= 1'b0;
          rdata_q  <= M_AXI_RDATA;
          resp_q   <= M_AXI_RRESP;
          done0_q  <= !grant_q;
          done1_q  <=  grant_q;
          state_q  <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ0_DONE     = done0_q;
  assign REQ1_DONE     = done1_q;
  assign RSP_RDATA     = rdata_q;
  assign RSP_RESP      = resp_q;
  assign M_AXI_AWADDR  = {addr_q, 2'b00};
  assign M_AXI_ARADDR  = {addr_q, 2'b00};
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_RREADY  = rready_q;
endmodule
